tdc_readout_scheduler: RTL and testbench

Sequences event readout from N_SRC HPTDC output FIFOs into the single 64-bit event packer and serial transmit path. Each accepted trigger opens one frame. Sources are then visited in ascending index order, and each source's words are popped and forwarded until its trailer arrives, its FIFO stays empty too long, or its word limit is hit. The frame is then closed and the block holds until the serial link reports completion. It sits between the TDC FIFOs and the packer, and owns every FIFO read-enable in the readout path.

---
 rtl/tdc_readout_scheduler_pkg.sv | 32 +++
 rtl/tdc_readout_scheduler_next_set_index.sv | 25 ++
 rtl/tdc_readout_scheduler.sv | 175 +++++++++++++++++
 tb/tb_tdc_readout_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_readout_scheduler_pkg.sv
// Shared definitions for the TDC readout scheduler: TDC word-type codes,
// FSM state encoding and default sizing.
package tdc_readout_scheduler_pkg;

  localparam int N_SRC_DEFAULT     = 4;
  localparam int TIMEOUT_DEFAULT   = 1023;
  localparam int MAX_WORDS_DEFAULT = 128;

  localparam logic [3:0] WT_HEADER     = 4'b0001;
  localparam logic [3:0] WT_WORD_COUNT = 4'b0010;
  localparam logic [3:0] WT_TRAILER    = 4'b0011;
  localparam logic [3:0] WT_LEADING    = 4'b0100;
  localparam logic [3:0] WT_TRAILING   = 4'b0101;
  localparam logic [3:0] WT_ERROR      = 4'b0110;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SELECT,
    S_POP,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_CLOSE,
    S_TX_WAIT
  } state_t;

  function automatic logic is_trailer(input logic [31:0] word);
    return word[31:28] == WT_TRAILER;
  endfunction

endpackage

// File: rtl/tdc_readout_scheduler_next_set_index.sv
// Combinational priority encoder: lowest set mask bit strictly above idx
// (or the lowest set bit overall when from_start), plus a none-left flag.
module next_set_index #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [2:0]   idx,
  input  logic         from_start,
  output logic [2:0]   next_idx,
  output logic         none_left
);

  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    // Scanning downward lets the lowest qualifying bit win.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || i > int'(idx))) begin
        next_idx  = 3'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdc_readout_scheduler.sv
// Frame-based readout of N_SRC TDC FIFOs into one word stream: one frame per
// trigger, sources in ascending order, >=3 cycles per word, all outputs registered.
module tdc_readout_scheduler
  import tdc_readout_scheduler_pkg::*;
#(
  parameter int N_SRC     = N_SRC_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 event_pending,
  output logic                 event_ack,
  input  logic [N_SRC-1:0]     src_enable,
  input  logic [N_SRC-1:0]     src_empty,
  output logic [N_SRC-1:0]     src_read_enable,
  input  logic [N_SRC-1:0]     src_ready,
  input  logic [32*N_SRC-1:0]  src_data,
  output logic [31:0]          mux_data,
  output logic                 mux_valid,
  output logic [2:0]           mux_src,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic [12:0]          word_count,
  output logic                 data_ready_for_transmit,
  input  logic                 serial_transmit_complete,
  output logic [N_SRC-1:0]     timeout_flags,
  output logic [N_SRC-1:0]     overflow_flags,
  output logic                 busy
);

  localparam int EW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(MAX_WORDS + 1);

  state_t           state;
  logic [N_SRC-1:0] mask;
  logic [2:0]       idx;
  logic [EW-1:0]    empty_cnt;
  logic [CW-1:0]    src_cnt;
  logic [31:0]      word_q;
  logic [N_SRC-1:0] idx_onehot;
  logic [31:0]      sel_data;
  logic [2:0]       next_idx;
  logic             none_left;

  assign idx_onehot = N_SRC'(1) << idx;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (int'(idx) == i) sel_data = src_data[32*i +: 32];
    end
  end

  next_set_index #(.N(N_SRC)) u_next_set_index (
    .mask       (mask),
    .idx        (idx),
    .from_start (state == S_START),
    .next_idx   (next_idx),
    .none_left  (none_left)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= S_IDLE;
      mask                    <= '0;
      idx                     <= '0;
      empty_cnt               <= '0;
      src_cnt                 <= '0;
      word_q                  <= '0;
      event_ack               <= 1'b0;
      src_read_enable         <= '0;
      mux_data                <= '0;
      mux_valid               <= 1'b0;
      mux_src                 <= '0;
      frame_start             <= 1'b0;
      frame_end               <= 1'b0;
      word_count              <= '0;
      data_ready_for_transmit <= 1'b0;
      timeout_flags           <= '0;
      overflow_flags          <= '0;
      busy                    <= 1'b0;
    end else begin
      event_ack       <= 1'b0;
      src_read_enable <= '0;
      mux_valid       <= 1'b0;
      frame_start     <= 1'b0;
      frame_end       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (event_pending) begin
            event_ack <= 1'b1;
            mask      <= src_enable;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          frame_start    <= 1'b1;
          word_count     <= '0;
          timeout_flags  <= '0;
          overflow_flags <= '0;
          empty_cnt      <= '0;
          src_cnt        <= '0;
          // An empty mask still produces a (zero-word) frame.
          if (none_left) begin
            state <= S_CLOSE;
          end else begin
            idx   <= next_idx;
            state <= S_SELECT;
          end
        end
        S_SELECT: state <= S_POP;
        S_POP: begin
          if ((src_empty & idx_onehot) == '0) begin
            src_read_enable <= idx_onehot;
            state           <= S_WAIT;
          end else if (empty_cnt == EW'(TIMEOUT - 1)) begin
            timeout_flags <= timeout_flags | idx_onehot;
            state         <= S_NEXT;
          end else begin
            empty_cnt <= empty_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if ((src_ready & idx_onehot) != '0) begin
            word_q <= sel_data;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          mux_data  <= word_q;
          mux_src   <= idx;
          mux_valid <= 1'b1;
          if (word_count != '1) word_count <= word_count + 1'b1;
          src_cnt <= src_cnt + 1'b1;
          // A trailer closes the source even when it is also the last allowed word.
          if (is_trailer(word_q)) begin
            state <= S_NEXT;
          end else if (src_cnt == CW'(MAX_WORDS - 1)) begin
            overflow_flags <= overflow_flags | idx_onehot;
            state          <= S_NEXT;
          end else begin
            empty_cnt <= '0;
            state     <= S_POP;
          end
        end
        S_NEXT: begin
          src_cnt   <= '0;
          empty_cnt <= '0;
          if (none_left) begin
            state <= S_CLOSE;
          end else begin
            idx   <= next_idx;
            state <= S_SELECT;
          end
        end
        S_CLOSE: begin
          frame_end               <= 1'b1;
          data_ready_for_transmit <= 1'b1;
          state                   <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (serial_transmit_complete) begin
            data_ready_for_transmit <= 1'b0;
            busy                    <= 1'b0;
            state                   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_readout_scheduler.sv
// Bench for tdc_readout_scheduler: FIFO models with random ready latency and
// a frame-level reference model of which words each frame must forward.
module tb_tdc_readout_scheduler;

  localparam int N   = 4;
  localparam int TO  = 1023;
  localparam int MW  = 4;
  localparam int DEP = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            event_pending = 1'b0;
  logic            event_ack;
  logic [N-1:0]    src_enable = '0;
  logic [N-1:0]    src_empty = '1;
  logic [N-1:0]    src_read_enable;
  logic [N-1:0]    src_ready = '0;
  logic [32*N-1:0] src_data = '0;
  logic [31:0]     mux_data;
  logic            mux_valid;
  logic [2:0]      mux_src;
  logic            frame_start;
  logic            frame_end;
  logic [12:0]     word_count;
  logic            data_ready_for_transmit;
  logic            serial_transmit_complete = 1'b0;
  logic [N-1:0]    timeout_flags;
  logic [N-1:0]    overflow_flags;
  logic            busy;

  tdc_readout_scheduler #(.N_SRC(N), .TIMEOUT(TO), .MAX_WORDS(MW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .event_pending            (event_pending),
    .event_ack                (event_ack),
    .src_enable               (src_enable),
    .src_empty                (src_empty),
    .src_read_enable          (src_read_enable),
    .src_ready                (src_ready),
    .src_data                 (src_data),
    .mux_data                 (mux_data),
    .mux_valid                (mux_valid),
    .mux_src                  (mux_src),
    .frame_start              (frame_start),
    .frame_end                (frame_end),
    .word_count               (word_count),
    .data_ready_for_transmit  (data_ready_for_transmit),
    .serial_transmit_complete (serial_transmit_complete),
    .timeout_flags            (timeout_flags),
    .overflow_flags           (overflow_flags),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO contents and ready-latency model
  logic [31:0] mem [N][DEP];
  int head [N];
  int tail [N];
  int rcnt [N];
  int rdy_max = 0;

  // Observations
  int cyc = 0, n_ack, n_fs, n_fe, ack_cyc, fs_cyc, fe_cyc, cpl_cyc, pop_cyc, first_gap;
  int onehot_viol, overlap_viol, n_obs;
  int pops [N];
  logic [31:0] obs_data [64];
  logic [2:0]  obs_src  [64];

  // Reference expectations
  int n_exp;
  logic [31:0]  exp_data [64];
  logic [2:0]   exp_src  [64];
  logic [N-1:0] exp_to, exp_ov;
  int exp_left [N];
  int exp_pops [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    src_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rcnt[i] > 0) begin
        rcnt[i]--;
        if (rcnt[i] == 0) src_ready[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (src_read_enable[i]) begin
        if (head[i] < tail[i]) begin
          src_data[32*i +: 32] = mem[i][head[i]];
          head[i]++;
        end
        rcnt[i] = $urandom_range(rdy_max, 0);
        if (rcnt[i] == 0) src_ready[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) src_empty[i] = (head[i] == tail[i]);
  end

  always @(negedge clk) begin
    cyc++;
    if (event_ack) begin n_ack++; ack_cyc = cyc; end
    if (frame_start) begin n_fs++; fs_cyc = cyc; end
    if (frame_end) begin n_fe++; fe_cyc = cyc; end
    if (serial_transmit_complete) cpl_cyc = cyc;
    if ($countones(src_read_enable) > 1) onehot_viol++;
    if (|src_read_enable && mux_valid) overlap_viol++;
    for (int i = 0; i < N; i++) if (src_read_enable[i]) pops[i]++;
    if (|src_read_enable) pop_cyc = cyc;
    if (mux_valid && n_obs < 64) begin
      if (n_obs == 0) first_gap = cyc - pop_cyc;
      obs_data[n_obs] = mux_data;
      obs_src[n_obs]  = mux_src;
      n_obs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; rcnt[i] = 0;
    end
  endtask

  task automatic push(input int s, input logic [31:0] w);
    if (tail[s] < DEP) begin
      mem[s][tail[s]] = w;
      tail[s]++;
    end
  endtask

  // Model: per enabled source, ascending, take words until a trailer, MW words, or an empty FIFO.
  task automatic setup_frame(input logic [N-1:0] m);
    int h, n;
    bit done;
    logic [31:0] w;
    src_enable = m;
    n_ack = 0; n_fs = 0; n_fe = 0; n_obs = 0; onehot_viol = 0; overlap_viol = 0;
    ack_cyc = 0; fs_cyc = 0; fe_cyc = 0; first_gap = -1;
    for (int i = 0; i < N; i++) pops[i] = 0;
    n_exp = 0; exp_to = '0; exp_ov = '0;
    for (int i = 0; i < N; i++) begin
      h = head[i];
      if (m[i]) begin
        n = 0; done = 0;
        while (!done) begin
          if (h == tail[i]) begin
            exp_to[i] = 1'b1; done = 1;
          end else begin
            w = mem[i][h]; h++; n++;
            exp_data[n_exp] = w; exp_src[n_exp] = 3'(i); n_exp++;
            if (w[31:28] == 4'b0011) done = 1;
            else if (n == MW) begin exp_ov[i] = 1'b1; done = 1; end
          end
        end
      end
      exp_left[i] = tail[i] - h;
      exp_pops[i] = h - head[i];
    end
  endtask

  task automatic accept();
    int k = 0;
    event_pending = 1'b1;
    while (n_ack == 0 && k < 20) begin tick(); k++; end
    if (n_ack == 0) check("ack_seen", 0, 1);
    event_pending = 1'b0;
  endtask

  task automatic check_frame();
    int k = 0;
    while (!data_ready_for_transmit && k < 6000) begin tick(); k++; end
    check("dr_seen", data_ready_for_transmit, 1);
    @(negedge clk); #1;
    check("ack_cnt", n_ack, 1);
    check("fs_lat", fs_cyc - ack_cyc, 1);
    check("fs_cnt", n_fs, 1);
    check("fe_cnt", n_fe, 1);
    check("nwords", n_obs, n_exp);
    for (int j = 0; j < n_exp && j < n_obs; j++) begin
      check($sformatf("data%0d", j), obs_data[j], exp_data[j]);
      check($sformatf("src%0d", j), 32'(obs_src[j]), 32'(exp_src[j]));
    end
    check("word_count", 32'(word_count), n_exp);
    check("timeout_flags", 32'(timeout_flags), 32'(exp_to));
    check("overflow_flags", 32'(overflow_flags), 32'(exp_ov));
    for (int i = 0; i < N; i++) begin
      check($sformatf("pops%0d", i), pops[i], exp_pops[i]);
      check($sformatf("left%0d", i), tail[i] - head[i], exp_left[i]);
    end
    check("onehot_viol", onehot_viol, 0);
    check("overlap_viol", overlap_viol, 0);
    check("busy_tx", busy, 1);
  endtask

  task automatic complete();
    @(posedge clk); #1;
    serial_transmit_complete = 1'b1;
    tick();
    serial_transmit_complete = 1'b0;
    tick();
    check("dr_clear", data_ready_for_transmit, 0);
    check("busy_clear", busy, 0);
  endtask

  logic [3:0] wtypes [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF};
  logic [3:0] nontrl [5] = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6};

  initial begin
    int k, g;
    clear_fifos();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_rd", 32'(src_read_enable), 0);
    check("rst_dr", data_ready_for_transmit, 0);
    check("rst_wc", 32'(word_count), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Two sources, immediate ready; stray completion mid-frame is ignored
    rdy_max = 0;
    clear_fifos();
    push(0, 32'h1000_00A1); push(0, 32'h4000_00A2); push(0, 32'h3000_00A3);
    push(1, 32'h1000_00B1); push(1, 32'h3000_00B2);
    setup_frame(4'b0011);
    accept();
    serial_transmit_complete = 1'b1; tick(); serial_transmit_complete = 1'b0;
    check_frame();
    check("t1_words", n_obs, 5);
    check("t1_first_gap", first_gap, 2);
    tick();
    check("t1_dr_hold", data_ready_for_transmit, 1);
    complete();

    // Empty source forever: timeout
    clear_fifos();
    setup_frame(4'b0100);
    accept();
    check_frame();
    g = fe_cyc - fs_cyc;
    check("to_gap", 32'(g >= TO && g <= TO + 8), 1);
    check("to_flag", 32'(timeout_flags), 32'h4);
    complete();

    // Word limit: 10 non-trailer words, MW of them forwarded
    rdy_max = 2;
    clear_fifos();
    for (int j = 0; j < 10; j++) push(0, {nontrl[j % 5], 28'(j)});
    setup_frame(4'b0001);
    accept();
    check_frame();
    check("ov_left", tail[0] - head[0], 6);
    check("ov_flag", 32'(overflow_flags), 32'h1);
    complete();

    // event_pending raised during TX_WAIT
    clear_fifos();
    push(3, 32'h1000_00C1); push(3, 32'h3000_00C2);
    setup_frame(4'b1000);
    accept();
    check_frame();
    clear_fifos();
    push(2, 32'h3000_00D1);
    setup_frame(4'b0100);
    event_pending = 1'b1;
    repeat (6) tick();
    check("no_ack_txwait", n_ack, 0);
    serial_transmit_complete = 1'b1; tick(); serial_transmit_complete = 1'b0;
    k = 0;
    while (n_ack == 0 && k < 20) begin tick(); k++; end
    check("early_ack_gap", ack_cyc - cpl_cyc, 2);
    event_pending = 1'b0;
    check_frame();
    complete();

    // Reset while polling an empty src1
    clear_fifos();
    push(0, 32'h3000_00E1);
    setup_frame(4'b0011);
    accept();
    k = 0;
    while (n_obs == 0 && k < 100) begin tick(); k++; end
    check("pre_rst_word", n_obs, 1);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", 32'(src_read_enable), 0);
    check("mid_rst_mv", mux_valid, 0);
    check("mid_rst_md", mux_data, 0);
    check("mid_rst_ms", 32'(mux_src), 0);
    check("mid_rst_wc", 32'(word_count), 0);
    check("mid_rst_fe", frame_end, 0);
    check("mid_rst_tof", 32'(timeout_flags), 0);
    check("mid_rst_dr", data_ready_for_transmit, 0);
    repeat (3) tick();
    check("rst_no_fe", n_fe, 0);
    rst = 1'b1;
    tick();
    clear_fifos();
    push(1, 32'h1000_00F1); push(1, 32'h3000_00F2); push(2, 32'h3000_00F3);
    setup_frame(4'b0110);
    accept();
    check_frame();
    check("post_rst_src", 32'(obs_src[0]), 1);
    complete();

    // Empty mask
    clear_fifos();
    push(0, 32'h1000_0001);
    setup_frame(4'b0000);
    accept();
    check_frame();
    check("m0_words", n_obs, 0);
    complete();

    // Random frames
    for (int f = 0; f < 12; f++) begin
      rdy_max = $urandom_range(2, 0);
      clear_fifos();
      for (int i = 0; i < N; i++) begin
        k = $urandom_range(6, 0);
        for (int j = 0; j < k; j++) push(i, {wtypes[$urandom_range(7, 0)], 28'($urandom)});
      end
      setup_frame(4'($urandom_range(15, 0)));
      accept();
      check_frame();
      complete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
